// File: rtl/s444_phase_mon.sv
// Two-road traffic-light phase monitor: tracks the lamp phase sequence, reports the dwell
// of each completed phase and latches sticky error flags.
module s444_phase_mon #(
  parameter int DW = 8
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          CLR,
  input  logic [2:0]    LA,
  input  logic [2:0]    LB,
  output logic [2:0]    PHASE,
  output logic          DV,
  output logic [DW-1:0] DWELL,
  output logic          ERR_OH,
  output logic          ERR_CF,
  output logic          ERR_SQ
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_AG   = 3'd1,
    S_AY   = 3'd2,
    S_RA   = 3'd3,
    S_BG   = 3'd4,
    S_BY   = 3'd5,
    S_RB   = 3'd6
  } phase_t;

  localparam logic [2:0] LG = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b001;

  phase_t        state, state_n;
  logic [DW-1:0] cnt, cnt_n, cnt_inc;
  logic          dv_n;
  logic          new_oh, new_cf, new_sq;
  logic          one_hot, conflict;
  logic          is_ag, is_ay, is_bg, is_by, is_red;
  logic          hold, succ;
  phase_t        tgt;

  assign one_hot  = $onehot(LA) && $onehot(LB);
  assign conflict = (LA != LR) && (LB != LR);
  assign is_ag    = (LA == LG) && (LB == LR);
  assign is_ay    = (LA == LY) && (LB == LR);
  assign is_bg    = (LA == LR) && (LB == LG);
  assign is_by    = (LA == LR) && (LB == LY);
  assign is_red   = (LA == LR) && (LB == LR);
  assign cnt_inc  = (cnt == {DW{1'b1}}) ? cnt : cnt + DW'(1);

  // Hold/successor decode for the current phase; yellow phases have two legal exits.
  always_comb begin
    hold = 1'b0;
    succ = 1'b0;
    tgt  = S_INIT;
    case (state)
      S_AG: begin hold = is_ag;  succ = is_ay;           tgt = S_AY; end
      S_AY: begin hold = is_ay;  succ = is_red || is_bg; tgt = is_red ? S_RA : S_BG; end
      S_RA: begin hold = is_red; succ = is_bg;           tgt = S_BG; end
      S_BG: begin hold = is_bg;  succ = is_by;           tgt = S_BY; end
      S_BY: begin hold = is_by;  succ = is_red || is_ag; tgt = is_red ? S_RB : S_AG; end
      S_RB: begin hold = is_red; succ = is_ag;           tgt = S_AG; end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dv_n    = 1'b0;
    new_oh  = 1'b0;
    new_cf  = 1'b0;
    new_sq  = 1'b0;
    if (!one_hot) begin
      new_oh  = 1'b1;
      state_n = S_INIT;
      cnt_n   = '0;
    end else if (conflict) begin
      new_cf  = 1'b1;
      state_n = S_INIT;
      cnt_n   = '0;
    end else begin
      case (state)
        S_INIT: begin
          // One-hot without conflict here is always all-red or a green/yellow pattern.
          if (!is_red) begin
            cnt_n = DW'(1);
            if (is_ag)      state_n = S_AG;
            else if (is_ay) state_n = S_AY;
            else if (is_bg) state_n = S_BG;
            else            state_n = S_BY;
          end
        end
        S_AG, S_AY, S_RA, S_BG, S_BY, S_RB: begin
          if (hold) begin
            cnt_n = cnt_inc;
          end else if (succ) begin
            state_n = tgt;
            dv_n    = 1'b1;
            cnt_n   = DW'(1);
          end else begin
            new_sq  = 1'b1;
            state_n = S_INIT;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = S_INIT;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state  <= S_INIT;
      cnt    <= '0;
      DV     <= 1'b0;
      DWELL  <= '0;
      ERR_OH <= 1'b0;
      ERR_CF <= 1'b0;
      ERR_SQ <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      DV     <= dv_n;
      if (dv_n) DWELL <= cnt;
      // CLR drops old flags but never masks an error seen in the same cycle.
      ERR_OH <= (ERR_OH && !CLR) || new_oh;
      ERR_CF <= (ERR_CF && !CLR) || new_cf;
      ERR_SQ <= (ERR_SQ && !CLR) || new_sq;
    end
  end

  assign PHASE = state;

endmodule

// File: tb/tb_s444_phase_mon.sv
// Directed scoreboard bench for s444_phase_mon: a DW=8 instance checked every step and a
// DW=4 instance used for dwell saturation.
module tb_s444_phase_mon;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  typedef struct packed {
    logic [2:0] ph;
    logic       dv;
    logic [7:0] dw;
    logic [2:0] err;
  } exp_t;

  logic       CK, RST, CLR;
  logic [2:0] LA, LB;
  logic [2:0] PHASE, PHASE4;
  logic       DV, DV4;
  logic [7:0] DWELL;
  logic [3:0] DWELL4;
  logic       ERR_OH, ERR_CF, ERR_SQ;
  logic       ERR_OH4, ERR_CF4, ERR_SQ4;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  s444_phase_mon #(.DW(8)) dut (
    .CK(CK), .RST(RST), .CLR(CLR), .LA(LA), .LB(LB),
    .PHASE(PHASE), .DV(DV), .DWELL(DWELL),
    .ERR_OH(ERR_OH), .ERR_CF(ERR_CF), .ERR_SQ(ERR_SQ)
  );

  s444_phase_mon #(.DW(4)) dut4 (
    .CK(CK), .RST(RST), .CLR(CLR), .LA(LA), .LB(LB),
    .PHASE(PHASE4), .DV(DV4), .DWELL(DWELL4),
    .ERR_OH(ERR_OH4), .ERR_CF(ERR_CF4), .ERR_SQ(ERR_SQ4)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag);
    exp_t e, o;
    e = sb.pop_front();
    o = {PHASE, DV, DWELL, {ERR_OH, ERR_CF, ERR_SQ}};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed ph=%0d dv=%0b dw=%0d err=%b expected ph=%0d dv=%0b dw=%0d err=%b",
             tag, o.ph, o.dv, o.dw, o.err, e.ph, e.dv, e.dw, e.err);
    end
  endtask

  task automatic step(input logic [2:0] la, input logic [2:0] lb, input logic clr,
                      input logic [2:0] ph, input logic dv, input logic [7:0] dw,
                      input logic [2:0] err, input string tag);
    LA = la; LB = lb; CLR = clr;
    sb.push_back({ph, dv, dw, err});
    @(posedge CK); #1;
    check(tag);
  endtask

  task automatic check4(input logic dv, input logic [3:0] dw, input string tag);
    checks++;
    assert ({DV4, DWELL4} === {dv, dw}) else begin
      errors++;
      $error("FAIL %s: observed dv=%0b dw=%0d expected dv=%0b dw=%0d", tag, DV4, DWELL4, dv, dw);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; CLR = 1'b0; LA = R; LB = R;
    #2;
    sb.push_back('0);
    check("reset_state");
    check4(1'b0, 4'd0, "reset_state_dw4");
    #10 RST = 1'b0;

    // Legal cycle: AG5 AY2 BG4 BY2 RB3 AG
    step(R, R, 0, 0, 0, 0, 3'b000, "init_all_red");
    for (int i = 0; i < 5; i++) step(G, R, 0, 1, 0, 0, 3'b000, "ag_dwell");
    step(Y, R, 0, 2, 1, 5, 3'b000, "ag_done");
    step(Y, R, 0, 2, 0, 5, 3'b000, "ay_hold");
    step(R, G, 0, 4, 1, 2, 3'b000, "ay_done");
    for (int i = 0; i < 3; i++) step(R, G, 0, 4, 0, 2, 3'b000, "bg_hold");
    step(R, Y, 0, 5, 1, 4, 3'b000, "bg_done");
    step(R, Y, 0, 5, 0, 4, 3'b000, "by_hold");
    step(R, R, 0, 6, 1, 2, 3'b000, "by_done");
    for (int i = 0; i < 2; i++) step(R, R, 0, 6, 0, 2, 3'b000, "rb_hold");
    step(G, R, 0, 1, 1, 3, 3'b000, "rb_done");

    // Conflict from AG, sticky until CLR
    step(G, G, 0, 0, 0, 3, 3'b010, "conflict");
    for (int i = 0; i < 2; i++) step(R, R, 0, 0, 0, 3, 3'b010, "cf_sticky");
    step(R, R, 1, 0, 0, 3, 3'b000, "cf_clear");

    // One-hot has priority over conflict; CLR with a fresh violation keeps only the new flag
    step(3'b110, G, 0, 0, 0, 3, 3'b100, "onehot_prio");
    step(G, G, 1, 0, 0, 3, 3'b010, "clr_with_new_err");
    step(R, R, 1, 0, 0, 3, 3'b000, "clr_all");

    // Illegal successor, recovery into BY, CLR leaves phase/counter alone
    step(G, R, 0, 1, 0, 3, 3'b000, "enter_ag");
    step(R, G, 0, 0, 0, 3, 3'b001, "ag_to_bg_illegal");
    step(R, Y, 0, 5, 0, 3, 3'b001, "recover_by");
    step(R, Y, 1, 5, 0, 3, 3'b000, "clr_in_by");
    step(R, R, 0, 6, 1, 2, 3'b000, "by_dwell_after_clr");

    // Saturation: 20 AG samples
    step(G, R, 0, 1, 1, 1, 3'b000, "rb_to_ag");
    for (int i = 0; i < 19; i++) step(G, R, 0, 1, 0, 1, 3'b000, "ag_long");
    step(Y, R, 0, 2, 1, 20, 3'b000, "ag_long_done");
    check4(1'b1, 4'd15, "dwell_saturated");

    // All-red in BG is a sequence error
    step(R, G, 0, 4, 1, 1, 3'b000, "ay_to_bg");
    step(R, R, 0, 0, 0, 1, 3'b001, "bg_all_red");

    // Reset in the 3rd BG cycle discards the partial dwell
    step(R, G, 1, 4, 0, 1, 3'b000, "bg_enter_clr");
    for (int i = 0; i < 2; i++) step(R, G, 0, 4, 0, 1, 3'b000, "bg_pre_reset");
    #2 RST = 1'b1;
    #1;
    sb.push_back('0);
    check("async_reset");
    check4(1'b0, 4'd0, "async_reset_dw4");
    #2 RST = 1'b0;
    step(R, G, 0, 4, 0, 0, 3'b000, "bg_after_reset");
    step(R, Y, 0, 5, 1, 1, 3'b000, "dwell_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
